mult_seq_ctrl: RTL

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequencer for a shift-add multiplier: buffers operand pairs in a 2-deep FIFO,
// issues load pulses, captures results into a backpressured output register.
module mult_seq_ctrl #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic             out_cout,
  output logic             mult_load,
  output logic [N-1:0]     mult_a,
  output logic [N-1:0]     mult_b,
  input  logic             mult_valid,
  input  logic [2*N-1:0]   mult_p,
  input  logic             mult_cout,
  output logic             busy,
  output logic             err
);

  localparam int WD_MAX = 2 * N + 4;
  localparam int WD_W   = $clog2(2 * N + 5);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  logic [N-1:0]      fifo_a_reg [2];
  logic [N-1:0]      fifo_b_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [1:0]        entry_we;

  logic [WD_W-1:0]   wd_cnt_reg;
  logic [WD_W-1:0]   wd_cnt_next;
  logic [N-1:0]      mult_a_reg;
  logic [N-1:0]      mult_b_reg;
  logic [2*N-1:0]    out_p_reg;
  logic              out_cout_reg;
  logic              out_valid_reg;
  logic              err_reg;

  logic              push;
  logic              pop;
  logic              capture;
  logic              wd_fire;
  logic              fifo_nempty;
  logic              out_free;

  // in_ready depends only on occupancy and reset, never on in_valid
  assign in_ready    = rst_n & (count_reg < 2'd2);
  assign push        = in_valid & in_ready;
  assign fifo_nempty = (count_reg != 2'd0);
  assign out_free    = ~out_valid_reg | out_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_entry_we
      assign entry_we[gi] = push & (wr_ptr_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    wd_cnt_next = wd_cnt_reg;
    pop         = 1'b0;
    capture     = 1'b0;
    wd_fire     = 1'b0;
    mult_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_nempty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        mult_load   = 1'b1;
        wd_cnt_next = '0;
        state_next  = WAIT;
      end
      WAIT: begin
        if (mult_valid) begin
          // a full, unconsumed output register stalls here; the multiplier holds its result
          if (out_free) begin
            capture = 1'b1;
            if (fifo_nempty) begin
              pop        = 1'b1;
              state_next = LOAD;
            end else begin
              state_next = IDLE;
            end
          end
        end else if (wd_cnt_reg == WD_W'(WD_MAX - 1)) begin
          wd_fire     = 1'b1;
          wd_cnt_next = '0;
          state_next  = IDLE;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wd_cnt_reg <= wd_cnt_next;
      if (wd_fire) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_reg
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (entry_we[i]) begin
        fifo_a_reg[i] <= in_a;
        fifo_b_reg[i] <= in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      mult_a_reg <= '0;
      mult_b_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        mult_a_reg <= fifo_a_reg[rd_ptr_reg];
        mult_b_reg <= fifo_b_reg[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_p_reg     <= '0;
      out_cout_reg  <= 1'b0;
    end else if (capture) begin
      out_valid_reg <= 1'b1;
      out_p_reg     <= mult_p;
      out_cout_reg  <= mult_cout;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_p     = out_p_reg;
  assign out_cout  = out_cout_reg;
  assign mult_a    = mult_a_reg;
  assign mult_b    = mult_b_reg;
  assign err       = err_reg;
  assign busy      = rst_n & ((state_reg != IDLE) | fifo_nempty);

endmodule
